// File: rtl/acc_mac_argmax.sv
// acc_mac_argmax: per-class MAC over a streamed frame, then argmax scan.
// Define ACC_SAT_EN to saturate accumulator updates instead of wrapping.
module acc_mac_argmax #(
  parameter int TAPS      = 9,
  parameter int NUM_CLASS = 10,
  parameter int DW        = 8,
  parameter int WW        = 8,
  parameter int ACCW      = 20,
  parameter int IDXW      = 4,
  parameter int WAW       = 7
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic [15:0]            Rm,
  input  logic [15:0]            Rn,
  output logic [IDXW-1:0]        max_index,
  output logic signed [ACCW-1:0] max_value,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic                   drop_o
);
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW = WW + DW;
  localparam int SW = ((ACCW > PW) ? ACCW : PW) + 1;

  typedef enum logic {ACCUM, SCAN} state_t;
  state_t state_q, state_d;

  logic signed [WW-1:0]   w      [NUM_CLASS][TAPS];
  logic signed [ACCW-1:0] acc    [NUM_CLASS];
  logic signed [ACCW-1:0] acc_nx [NUM_CLASS];
  logic signed [PW-1:0]   prod   [NUM_CLASS];
  logic signed [SW-1:0]   sum    [NUM_CLASS];

  logic [CW-1:0]          cnt;
  logic [IDXW-1:0]        sc, best_idx, cand_idx;
  logic signed [ACCW-1:0] best_val, cand_val, sel_val;
  logic                   clr, in_s, wr, accept, last, scan_done;
  logic [WAW-1:0]         wa;
  logic [WAW:0]           e_lo, e_hi;
  logic signed [DW-1:0]   x;
  logic                   unused_rn;

  assign clr       = Rn[15];
  assign in_s      = Rn[0] & ~clr;
  assign wa        = Rn[WAW:1];
  assign wr        = ~clr & ~Rn[0] & (wa != '0);
  assign e_lo      = {wa - WAW'(1), 1'b0};
  assign e_hi      = {wa - WAW'(1), 1'b1};
  assign x         = Rm[DW-1:0];
  assign unused_rn = ^Rn[14:WAW+1];

  assign accept    = in_s & (state_q == ACCUM);
  assign last      = accept & (cnt == CW'(TAPS-1));
  assign scan_done = ~clr & (state_q == SCAN)
                   & (sc == IDXW'(NUM_CLASS-1));
  assign busy_o    = (state_q == SCAN);

  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      prod[c]   = PW'(w[c][cnt]) * PW'(x);
      sum[c]    = SW'(acc[c]) + SW'(prod[c]);
      acc_nx[c] = sum[c][ACCW-1:0];
`ifdef ACC_SAT_EN
      if (sum[c][SW-1:ACCW-1] != {(SW-ACCW+1){sum[c][SW-1]}})
        acc_nx[c] = sum[c][SW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                 : {1'b0, {(ACCW-1){1'b1}}};
`endif
    end
  end

  // Strict greater keeps the lowest index on ties.
  always_comb begin
    sel_val  = acc[sc];
    cand_val = best_val;
    cand_idx = best_idx;
    if (sc == '0 || sel_val > best_val) begin
      cand_val = sel_val;
      cand_idx = sc;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      clr:       state_d = ACCUM;
      last:      state_d = SCAN;
      scan_done: state_d = ACCUM;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        acc[c] <= '0;
        for (int t = 0; t < TAPS; t++) w[c][t] <= '0;
      end
      cnt       <= '0;
      sc        <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      max_index <= '0;
      max_value <= '0;
      valid_o   <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (wr) begin
        for (int c = 0; c < NUM_CLASS; c++)
          for (int t = 0; t < TAPS; t++)
            if ((WAW+1)'(c*TAPS+t) == e_lo)
              w[c][t] <= Rm[WW-1:0];
            else if ((WAW+1)'(c*TAPS+t) == e_hi)
              w[c][t] <= Rm[8+WW-1:8];
      end
      if (clr) begin
        for (int c = 0; c < NUM_CLASS; c++) acc[c] <= '0;
        cnt    <= '0;
        sc     <= '0;
        drop_o <= 1'b0;
      end else if (accept) begin
        acc <= acc_nx;
        cnt <= last ? '0 : cnt + CW'(1);
      end else if (state_q == SCAN) begin
        if (in_s) drop_o <= 1'b1;
        best_val <= cand_val;
        best_idx <= cand_idx;
        sc       <= sc + IDXW'(1);
        if (scan_done) begin
          max_index <= cand_idx;
          max_value <= cand_val;
          valid_o   <= 1'b1;
          sc        <= '0;
          for (int c = 0; c < NUM_CLASS; c++) acc[c] <= '0;
        end
      end
    end
  end
endmodule

// File: doc/acc_mac_argmax.md
Name: acc_mac_argmax

Overview:
Parametrised successor to the single-frame conv/argmax accelerator attached to OurCPU through the Rm/Rn operand buses. It stores a NUM_CLASS x TAPS signed weight bank, streams TAPS signed input samples per frame, and computes one dot product per class in parallel. A sequential argmax scan then reports the winning class index and its score. It adds a result handshake, a soft clear, drop detection and configurable class count, tap count and widths.

Parameters:
TAPS, 9, samples per frame (taps per class)
NUM_CLASS, 10, number of class accumulators
DW, 8, signed input sample width (Rm[DW-1:0])
WW, 8, signed weight width; two weights per write, WW<=8
ACCW, 20, signed accumulator/score width
IDXW, 4, class index width, 2^IDXW >= NUM_CLASS
WAW, 7, write-pair index field width in Rn[WAW:1]

Ports:
clk_i  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
Rm  input  16  data: sample in Rm[DW-1:0] when IN=1; weight pair {Rm[15:8],Rm[7:0]} on write
Rn  input  16  control: Rn[0]=IN strobe; Rn[WAW:1]=Wen pair index (0=none); Rn[15]=soft clear
max_index  output  IDXW  winning class, held until next result
max_value  output  ACCW  winning score, held until next result
valid_o  output  1  one-cycle pulse when max_index/max_value update
busy_o  output  1  high while in SCAN
drop_o  output  1  sticky: a sample arrived during SCAN

Behaviour:
- Reset: weights, accumulators, sample counter, max_index, max_value, valid_o, busy_o, drop_o all 0; FSM=ACCUM. Reset mid-SCAN aborts; no valid_o pulse.
- Command priority per cycle: soft clear > IN > weight write. IN=1 ignores the Wen field.
- Weight write (IN=0, Wen=k, 1<=k<=ceil(NUM_CLASS*TAPS/2)): entry 2(k-1) <= Rm[WW-1:0], entry 2(k-1)+1 <= Rm[8+WW-1:8]. Entry e maps to class e/TAPS, tap e%TAPS. Out-of-range k and entry indices >= NUM_CLASS*TAPS are ignored. Writes are accepted in any state and take effect for the next accepted sample.
- FSM ACCUM: IN=1 accepts sample x at tap t=sample counter. On each edge, acc[c] += sign-extend(w[c][t]*x) for all c. Counter increments. If t==TAPS-1, counter wraps to 0 and FSM moves to SCAN.
- FSM SCAN (busy_o=1): one class per cycle, c=0..NUM_CLASS-1. A running best is replaced only on strict greater (signed), so ties resolve to the lowest index. IN=1 during SCAN is dropped and sets drop_o; the sample is not buffered.
- SCAN completes at the NUM_CLASS-th edge after the last-sample edge. That edge registers max_index/max_value, clears all accumulators and returns the FSM to ACCUM. valid_o is high for exactly the following cycle. The next frame's first sample is accepted from that cycle.
- Soft clear (Rn[15]=1): clears accumulators, counter, busy_o and drop_o. FSM returns to ACCUM, no valid_o. Weights, max_index and max_value are kept.
- Arithmetic: product is WW+DW bits signed. Accumulation wraps modulo 2^ACCW unless the optional feature is enabled.

Optional Feature:
ACC_SAT_EN — when defined, each accumulator update saturates to [-2^(ACCW-1), 2^(ACCW-1)-1] and never wraps. When undefined, updates wrap two's complement. All other behaviour is identical.

Test Plan:
- Reset, then load all class-3 weights = 1 and others = 0. Stream x=1..9 -> valid_o 10 cycles after the 9th sample edge, max_index=3, max_value=45, busy_o high for 10 cycles.
- All weights 0, one frame of arbitrary samples -> max_index=0, max_value=0 (tie to lowest index).
- Class 7 weights = -1, others -2. Samples all 5 -> max_index=7, max_value=-45. Two frames back-to-back with no gap -> two valid_o pulses, second result independent of the first.
- Assert IN during SCAN -> drop_o=1, result unchanged. Soft clear -> drop_o=0, max_index held, no valid_o.
- Soft clear after 4 samples, then a full 9-sample frame -> result reflects only those 9 samples. Assert rst mid-SCAN -> all outputs 0, no valid_o.
- Set ACCW=12, weights 127, samples 127 -> with ACC_SAT_EN max_value=2047. Without it, the value equals the wrapped sum mod 4096 (sign-interpreted).
